// File: rtl/read_preamble_detect.sv
// Read-path preamble detector: finds the read preamble on sampled DQS, then captures one BL8/BL16 burst.
// Define READ_INTERAMBLE_EN to support seamless and short-interamble back-to-back reads.
module read_preamble_detect #(
  parameter int DQ_W        = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_en_i,
  input  logic [7:0]        pre_pattern_i,
  input  logic              burst_eight_i,
  input  logic [1:0]        dqs_bits_i,
  input  logic [2*DQ_W-1:0] dq_i,
  output logic [2*DQ_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              burst_done_o,
  output logic              preamble_err_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, SEARCH, DATA} state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [7:0]        sr_q, sr_d;
  logic [7:0]        srch_cnt_q, srch_cnt_d;
  logic [2:0]        beat_q, beat_d;
  logic              bl8_q, bl8_d;
  logic [2*DQ_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Pattern pairs compared ahead of the trailing 00; doubles as the minimum pair count.
  logic [2:0]        match_g;
  logic [3:0]        shamt;
  logic [9:0]        cand, target, mask;
  logic              match, timeout, last_beat;

`ifdef READ_INTERAMBLE_EN
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic [2:0]        match_g_q, match_g_d;
  assign match_g = match_g_q;
`else
  assign match_g = 3'd4;
`endif

  assign cand      = {sr_q, dqs_bits_i};
  assign target    = {pre_pattern_i, 2'b00};
  assign shamt     = {match_g, 1'b0} + 4'd2;
  assign mask      = ~(10'h3FF << shamt);
  assign match     = (((cand ^ target) & mask) == 10'd0) && (srch_cnt_q >= {5'd0, match_g});
  assign timeout   = (srch_cnt_q == TIMEOUT_LAST);
  assign last_beat = (beat_q == (bl8_q ? 3'd3 : 3'd7));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      srch_cnt_q <= '0;
      beat_q     <= '0;
      bl8_q      <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef READ_INTERAMBLE_EN
      gap_cnt_q  <= '0;
      match_g_q  <= 3'd4;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      srch_cnt_q <= srch_cnt_d;
      beat_q     <= beat_d;
      bl8_q      <= bl8_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef READ_INTERAMBLE_EN
      gap_cnt_q  <= gap_cnt_d;
      match_g_q  <= match_g_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    srch_cnt_d = srch_cnt_q;
    beat_d     = beat_q;
    bl8_d      = bl8_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef READ_INTERAMBLE_EN
    gap_cnt_d  = gap_cnt_q;
    match_g_d  = match_g_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef READ_INTERAMBLE_EN
        if (gap_cnt_q != 4'hF) gap_cnt_d = gap_cnt_q + 4'd1;
`endif
        if (rd_en_i) begin
          state_d    = SEARCH;
          bl8_d      = burst_eight_i;
          sr_d       = '0;
          srch_cnt_d = '0;
`ifdef READ_INTERAMBLE_EN
          match_g_d  = (gap_cnt_q >= 4'd1 && gap_cnt_q <= 4'd4) ? gap_cnt_q[2:0] : 3'd4;
`endif
        end
      end
      SEARCH: begin
        sr_d = cand[7:0];
        if (srch_cnt_q != 8'hFF) srch_cnt_d = srch_cnt_q + 8'd1;
        if (match) begin
          state_d = DATA;
          beat_d  = '0;
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DATA: begin
        data_d  = dq_i;
        valid_d = 1'b1;
        beat_d  = beat_q + 3'd1;
        if (last_beat) begin
          done_d  = 1'b1;
          state_d = IDLE;
          beat_d  = '0;
`ifdef READ_INTERAMBLE_EN
          // The done cycle is gap 1; a read issued on this last beat is gap 0 and runs seamlessly.
          gap_cnt_d = 4'd1;
          if (rd_en_i) begin
            state_d = DATA;
            bl8_d   = burst_eight_i;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_o         = data_q;
  assign data_valid_o   = valid_q;
  assign burst_done_o   = done_q;
  assign preamble_err_o = err_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: doc/read_preamble_detect.md
Name: read_preamble_detect

Overview:
- Read-path counterpart of the write preamble/interamble shifter in the DDR5 PHY.
- Samples the returned read DQS strobe, 2 bits per controller clock, and detects the expected read preamble: `pre_pattern_i` MSB-first, followed by 2'b00.
- On detection, opens a capture window for one BL8 or BL16 burst on DQ, driving a registered data/valid stream to the read datapath.
- Flags preamble timeouts and indicates burst completion to the read controller.

Parameters:
- DQ_W, 8: DQ lanes; each clock carries 2 beats, so the DQ bus is 2*DQ_W bits.
- TIMEOUT_CYC, 16: maximum SEARCH cycles before a preamble error (range 6..255).

Ports:
- clk_i  input  1  controller clock
- rst_i  input  1  asynchronous active-low reset
- rd_en_i  input  1  read-return window start; single-cycle pulse
- pre_pattern_i  input  8  expected preamble pattern, MSB sent first; static during a read
- burst_eight_i  input  1  1 = BL8 (4 data cycles), 0 = BL16 (8 data cycles); sampled with rd_en_i
- dqs_bits_i  input  2  sampled DQS pair; [1] is the earlier beat
- dq_i  input  2*DQ_W  sampled DQ pair; upper DQ_W bits are the earlier beat
- data_o  output  2*DQ_W  captured data
- data_valid_o  output  1  data_o valid
- burst_done_o  output  1  one-cycle pulse with the last valid data
- preamble_err_o  output  1  one-cycle pulse on timeout
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, `rst_i` low):
  - All outputs 0; FSM = IDLE; shift register, counters and latched burst length cleared.
  - Reset mid-burst drops the burst silently; no done or error pulse is generated.
- Shift register `sr[9:0]`:
  - In SEARCH, each cycle: `sr <= {sr[7:0], dqs_bits_i}`.
  - `sr` is cleared on entry to SEARCH.
  - `srch_cnt` counts cycles in SEARCH, saturating at 255.
- Full match:
  - Condition: `{sr[7:0], dqs_bits_i} == {pre_pattern_i, 2'b00}` AND `srch_cnt >= 4` (at least 5 pairs received).
  - The pair-count qualification prevents cleared zeros from false-matching.
- FSM:
  - IDLE:
    - `rd_en_i` -> SEARCH.
    - Latch `burst_eight_i`.
  - SEARCH:
    - Match -> DATA; the match cycle carries no data.
    - `srch_cnt == TIMEOUT_CYC-1` without a match -> pulse `preamble_err_o` the next cycle and go to IDLE.
    - Match and timeout in the same cycle: match wins.
  - DATA:
    - Beat counter runs 0..N-1, where N = 4 (BL8) or 8 (BL16).
    - `dq_i` is captured every DATA cycle.
    - Output lags capture by one cycle: `data_o`/`data_valid_o` register the beat seen in the previous cycle.
    - The last beat -> IDLE; `burst_done_o` asserts together with the last `data_valid_o`.
  - `rd_en_i` outside IDLE: ignored, unless the optional feature is enabled.
- Latency:
  - Match at cycle m.
  - First `dq_i` pair sampled at m+1.
  - First `data_valid_o` at m+2.
  - `data_valid_o` stays high for exactly N consecutive cycles.
- Widths: counters are 8-bit; the beat counter is 3-bit and does not wrap within a burst.

Optional Feature:
- Macro: `READ_INTERAMBLE_EN`. Supports back-to-back reads with a shortened interamble.
- With the macro:
  - `gap_cnt` (4-bit, saturating at 15) clears on `burst_done_o` and counts cycles spent in IDLE.
  - `rd_en_i` during the last DATA cycle (gap 0) is seamless:
    - Next burst goes straight DATA -> DATA with no preamble check.
    - New burst length is latched.
    - `data_valid_o` stays continuous.
  - `rd_en_i` in IDLE with `gap_cnt = g`, where 1 <= g <= 4:
    - SEARCH uses a short match: `{sr[2g-1:0], dqs_bits_i} == {pre_pattern_i[2g-1:0], 2'b00}`.
    - Qualifier: `srch_cnt >= g`.
  - `gap_cnt >= 5`: full match.
  - `rd_en_i` in DATA before the last cycle: ignored.
- Without the macro: always full match; `rd_en_i` outside IDLE is ignored; no `gap_cnt` logic is built.

Test Plan:
1. Basic BL16 read:
   - Stimulus: `pre_pattern_i = 8'hA5`, BL16; `rd_en_i` at cycle 0; DQS pairs from cycle 1 = 10,10,01,01,00; `dq_i` = 16'h0001..16'h0008 from cycle 6.
   - Response: `data_valid_o` high cycles 7..14, `data_o` = 0001..0008, `burst_done_o` at cycle 14.
2. BL8 read:
   - Stimulus: same preamble with `burst_eight_i = 1`.
   - Response: exactly 4 valid cycles; `burst_done_o` on the 4th; `busy_o` low the following cycle.
3. Timeout:
   - Stimulus: `rd_en_i`, then DQS stuck at 2'b11, `TIMEOUT_CYC = 16`.
   - Response: `preamble_err_o` pulses once 17 cycles after `rd_en_i`; no `data_valid_o`; FSM returns to IDLE.
4. False-match guard:
   - Stimulus: `pre_pattern_i = 8'h00`, DQS = 00 from cycle 1.
   - Response: match no earlier than the 5th pair (cycle 5); first `data_valid_o` at cycle 7.
5. Reset mid-burst:
   - Stimulus: `rst_i` low during the 3rd DATA cycle, held 2 cycles.
   - Response: all outputs 0 immediately; no `burst_done_o`; a new read afterwards completes normally.
6. `READ_INTERAMBLE_EN` back-to-back reads:
   - Stimulus: gap 0 -> second burst follows with no valid bubble; gap 2 with `pre_pattern_i = 8'hA5`, DQS 01,01,00 -> short match accepted.
   - Response: same gap 2 stimulus without the macro -> timeout error.
